// File: rtl/rf_cfg_pkg.sv
// rf_cfg_pkg: shared types, constants and command builder for the RF config sequencer
package rf_cfg_pkg;
  localparam int DATA_WIDTH = 8;
  localparam int CMD_LEN = 6;
  localparam int IDX_W = $clog2(CMD_LEN + 1);
  localparam int PARAM_W = (CMD_LEN - 1) * DATA_WIDTH;
  localparam logic [DATA_WIDTH-1:0] CMD_HEADER = 8'hC0;
  localparam logic [DATA_WIDTH-1:0] UART_CFG_SAFE = 8'h23;
  localparam logic [1:0] MODE_NORMAL = 2'b00;
  localparam logic [1:0] MODE_CONFIG = 2'b11;
  typedef enum logic [2:0] {IDLE, ENTER, SEND, RECV, RETRY, EXIT} state_e;
  typedef logic [CMD_LEN-1:0][DATA_WIDTH-1:0] cmd_t;
  // Byte 0 is the header; params follow MSB-first as ADDH, ADDL, SPED, CHAN, OPTION.
  function automatic cmd_t build_cmd(input logic [PARAM_W-1:0] p);
    cmd_t c;
    c[0] = CMD_HEADER;
    for (int i = 1; i < CMD_LEN; i++) c[i] = p[(CMD_LEN-1-i)*DATA_WIDTH +: DATA_WIDTH];
    return c;
  endfunction
endpackage

// File: rtl/rf_cfg_sequencer_if.sv
// rf_cfg_sequencer_if: byte-level link between the sequencer and the com_uart user ports
interface rf_cfg_sequencer_if;
  import rf_cfg_pkg::*;
  logic                  tx_use;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  rx_flag;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic [DATA_WIDTH-1:0] uart_cfg;
  modport master (output tx_use, tx_data, uart_cfg, input rx_flag, rx_data, rx_valid);
  modport slave (input tx_use, tx_data, uart_cfg, output rx_flag, rx_data, rx_valid);
endinterface

// File: rtl/rf_cfg_timer.sv
// rf_cfg_timer: clearable saturating up-counter with terminal-count compare
module rf_cfg_timer #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] limit_i,
  output logic         tc_o
);
  logic [W-1:0] cnt_q;
  always_ff @(posedge clk)
    cnt_q <= (rst || clr_i) ? '0 : (en_i && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  assign tc_o = cnt_q >= limit_i;
endmodule

// File: rtl/rf_cfg_sequencer.sv
// rf_cfg_sequencer: programs RF module parameters through com_uart with echo check and retries
module rf_cfg_sequencer
  import rf_cfg_pkg::*;
#(
  parameter int MODE_SETTLE = 1000,
  parameter int RX_TIMEOUT = 50000,
  parameter int RETRY_MAX = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [PARAM_W-1:0] cfg_params_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               error_o,
  output logic               rf_m0_o,
  output logic               rf_m1_o,
  rf_cfg_sequencer_if.master uart
);
  localparam int CW = $clog2((MODE_SETTLE > RX_TIMEOUT ? MODE_SETTLE : RX_TIMEOUT) + 1);
  localparam int AW = $clog2(RETRY_MAX + 2);
  state_e state_q, state_d;
  cmd_t cmd_q, cmd_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [AW-1:0] att_q, att_d;
  logic [1:0] mode_q, mode_d;
  logic [DATA_WIDTH-1:0] cfg_q, cfg_d;
  logic ph_q, ph_d, fail_q, fail_d, ok_q, ok_d;
  logic busy_q, busy_d, done_q, done_d, err_q, err_d, rx_prev_q;
  logic tmr_clr, tmr_en, tmr_tc, rx_edge, byte_ok, tx_use;
  logic [CW-1:0] limit;
  assign rx_edge = uart.rx_flag && !rx_prev_q;
  assign byte_ok = uart.rx_valid && uart.rx_data == cmd_q[idx_q];
  assign limit = (state_q == RECV) ? CW'(RX_TIMEOUT) : CW'(MODE_SETTLE);
  rf_cfg_timer #(.W(CW)) u_timer (
    .clk, .rst, .clr_i(tmr_clr), .en_i(tmr_en), .limit_i(limit), .tc_o(tmr_tc)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cmd_q <= '0;
      idx_q <= '0;
      att_q <= '0;
      mode_q <= MODE_NORMAL;
      cfg_q <= UART_CFG_SAFE;
      ph_q <= 1'b0;
      fail_q <= 1'b0;
      ok_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      rx_prev_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q <= cmd_d;
      idx_q <= idx_d;
      att_q <= att_d;
      mode_q <= mode_d;
      cfg_q <= cfg_d;
      ph_q <= ph_d;
      fail_q <= fail_d;
      ok_q <= ok_d;
      busy_q <= busy_d;
      done_q <= done_d;
      err_q <= err_d;
      rx_prev_q <= uart.rx_flag;
    end
  end
  always_comb begin
    state_d = state_q;
    cmd_d = cmd_q;
    idx_d = idx_q;
    att_d = att_q;
    mode_d = mode_q;
    cfg_d = cfg_q;
    ph_d = ph_q;
    fail_d = fail_q;
    ok_d = ok_q;
    busy_d = busy_q;
    done_d = 1'b0;
    err_d = err_q;
    tmr_clr = 1'b0;
    tmr_en = 1'b0;
    case (state_q)
      IDLE: if (start_i) begin
        cmd_d = build_cmd(cfg_params_i);
        err_d = 1'b0;
        busy_d = 1'b1;
        att_d = '0;
        mode_d = MODE_CONFIG;
        tmr_clr = 1'b1;
        state_d = ENTER;
      end
      ENTER: begin
        tmr_en = 1'b1;
        if (tmr_tc) begin
          idx_d = '0;
          ph_d = 1'b0;
          state_d = SEND;
        end
      end
      // ph_q=0 is the strobe cycle, ph_q=1 the gap cycle before the next byte
      SEND: begin
        ph_d = !ph_q;
        if (ph_q) idx_d = idx_q + 1'b1;
        if (ph_q && idx_q == IDX_W'(CMD_LEN - 1)) begin
          idx_d = '0;
          fail_d = 1'b0;
          tmr_clr = 1'b1;
          state_d = RECV;
        end
      end
      RECV: begin
        if (idx_q == IDX_W'(CMD_LEN)) begin
          ok_d = !fail_q;
          mode_d = fail_q ? mode_q : MODE_NORMAL;
          tmr_clr = 1'b1;
          state_d = fail_q ? RETRY : EXIT;
        end else if (rx_edge) begin
          tmr_clr = 1'b1;
          idx_d = idx_q + 1'b1;
          fail_d = fail_q || !byte_ok;
        end else if (tmr_tc) state_d = RETRY;
        else tmr_en = 1'b1;
      end
      RETRY: begin
        if (att_q < AW'(RETRY_MAX)) begin
          att_d = att_q + 1'b1;
          idx_d = '0;
          ph_d = 1'b0;
          state_d = SEND;
        end else begin
          ok_d = 1'b0;
          mode_d = MODE_NORMAL;
          tmr_clr = 1'b1;
          state_d = EXIT;
        end
      end
      EXIT: begin
        tmr_en = 1'b1;
        if (tmr_tc) begin
          busy_d = 1'b0;
          done_d = ok_q;
          err_d = !ok_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  assign tx_use = state_q == SEND && !ph_q;
  assign uart.tx_use = tx_use;
  assign uart.tx_data = tx_use ? cmd_q[idx_q] : '0;
  assign uart.uart_cfg = cfg_q;
  assign busy_o = busy_q;
  assign done_o = done_q;
  assign error_o = err_q;
  assign rf_m0_o = mode_q[0];
  assign rf_m1_o = mode_q[1];
endmodule

// File: tb/tb_rf_cfg_sequencer.sv
// tb_rf_cfg_sequencer: randomized scenarios against an attempt-level model of the config sequencer
module tb_rf_cfg_sequencer;
  localparam int MS = 20, RT = 300, RM = 2;
  logic clk = 0, rst = 1, start = 0;
  logic [39:0] cfg = '0;
  logic busy, done, error, m0, m1;
  rf_cfg_sequencer_if bus();
  rf_cfg_sequencer #(.MODE_SETTLE(MS), .RX_TIMEOUT(RT), .RETRY_MAX(RM)) dut (
    .clk(clk), .rst(rst), .start_i(start), .cfg_params_i(cfg), .busy_o(busy), .done_o(done),
    .error_o(error), .rf_m0_o(m0), .rf_m1_o(m1), .uart(bus)
  );
  always #5 clk = ~clk;
  int errors = 0, checks = 0;
  logic [7:0] txq[$];
  logic [7:0] exp_cmd[6];
  int done_cnt = 0, cfg_cycles = 0, pin_bad = 0, hi2 = 0;
  int run_base = 0, done_base = 0, cfg_base = 0, pin_base = 0, hi_base = 0;
  int echo_en = 0, bad_att = 0, inv_last = 0;
  logic prev_tx = 0;
  always @(negedge clk) begin
    if (bus.tx_use === 1'b1) begin
      txq.push_back(bus.tx_data);
      if (prev_tx) hi2++;
      if ({m1, m0} !== 2'b11) pin_bad++;
    end
    prev_tx = bus.tx_use;
    if (done === 1'b1) done_cnt++;
    if ({m1, m0} === 2'b11) cfg_cycles++;
  end
  // UART-side echo responder: answers each completed 6-byte command
  initial begin
    int handled, a;
    logic [7:0] b;
    handled = 0;
    bus.rx_flag = 0; bus.rx_data = 0; bus.rx_valid = 0;
    forever begin
      @(negedge clk);
      if (handled < run_base) handled = run_base;
      if (txq.size() >= handled + 6) begin
        a = (handled - run_base) / 6;
        handled += 6;
        if (echo_en != 0) begin
          repeat (3) @(negedge clk);
          for (int i = 0; i < 6; i++) begin
            b = exp_cmd[i];
            if (i == 3 && a < bad_att) b = b ^ 8'h01;
            bus.rx_data = b;
            bus.rx_valid = !(inv_last != 0 && i == 5);
            bus.rx_flag = 1;
            repeat (2) @(negedge clk);
            bus.rx_flag = 0;
            repeat (2) @(negedge clk);
          end
        end
      end
    end
  end
  // Attempt-level reference: an attempt succeeds only if echoed intact with all bytes valid.
  task automatic model(input int en, bad, inv, output int att, output int ok);
    ok = 0; att = 0;
    for (int a = 0; a <= RM; a++) begin
      att = a + 1;
      if (en != 0 && a >= bad && inv == 0) begin ok = 1; break; end
    end
  endtask
  function automatic int tx_mism(input int base, input int n);
    int m = 0;
    for (int k = 0; k < n; k++) if (txq[base + k] !== exp_cmd[k % 6]) m++;
    return m;
  endfunction
  task automatic launch(input logic [39:0] p, input int en, bad, inv);
    cfg = p;
    exp_cmd[0] = 8'hC0;
    for (int i = 1; i < 6; i++) exp_cmd[i] = p[(5 - i) * 8 +: 8];
    echo_en = en; bad_att = bad; inv_last = inv;
    run_base = txq.size(); done_base = done_cnt; cfg_base = cfg_cycles; pin_base = pin_bad; hi_base = hi2;
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
  endtask
  task automatic wait_idle(output bit to, output logic d_fall, output int cyc);
    to = 1; d_fall = 1'bx; cyc = 0;
    for (int i = 0; i < 20000; i++) begin
      if (busy === 1'b0) begin to = 0; d_fall = done; break; end
      @(negedge clk); cyc++;
    end
    repeat (2) @(negedge clk);
  endtask
  task automatic test_reset;
    rst = 1;
    repeat (3) @(negedge clk);
    checks++; if ({busy, done, error, bus.tx_use} !== 4'b0) begin errors++; $display("FAIL reset_flags got=%b exp=0000", {busy, done, error, bus.tx_use}); end
    checks++; if (bus.tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got=%h exp=00", bus.tx_data); end
    checks++; if ({m1, m0} !== 2'b00) begin errors++; $display("FAIL reset_pins got=%b exp=00", {m1, m0}); end
    checks++; if (bus.uart_cfg !== 8'h23) begin errors++; $display("FAIL reset_uart_cfg got=%h exp=23", bus.uart_cfg); end
    rst = 0;
    @(negedge clk);
  endtask
  task automatic test_basic;
    bit to; logic df; int cyc, n;
    launch(40'h00_01_1A_17_44, 1, 0, 0);
    wait_idle(to, df, cyc);
    n = txq.size() - run_base;
    checks++; if (to) begin errors++; $display("FAIL basic_timeout got=busy exp=idle"); end
    checks++; if (n != 6) begin errors++; $display("FAIL basic_tx_count got=%0d exp=6", n); end
    checks++; if (n == 6 && tx_mism(run_base, 6) != 0) begin errors++; $display("FAIL basic_tx_bytes got=%0d bad exp=0", tx_mism(run_base, 6)); end
    checks++; if (df !== 1'b1) begin errors++; $display("FAIL basic_done_with_busy_fall got=%b exp=1", df); end
    checks++; if (done_cnt - done_base != 1) begin errors++; $display("FAIL basic_done_pulses got=%0d exp=1", done_cnt - done_base); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL basic_error got=%b exp=0", error); end
    checks++; if (cfg_cycles - cfg_base < MS) begin errors++; $display("FAIL basic_cfg_pins got=%0d cycles exp>=%0d", cfg_cycles - cfg_base, MS); end
    checks++; if ({m1, m0} !== 2'b00) begin errors++; $display("FAIL basic_end_pins got=%b exp=00", {m1, m0}); end
    checks++; if (hi2 != hi_base || pin_bad != pin_base) begin errors++; $display("FAIL basic_strobe_shape got=%0d/%0d exp=0/0", hi2 - hi_base, pin_bad - pin_base); end
  endtask
  task automatic test_retry_mismatch;
    bit to; logic df; int cyc, n;
    launch(40'h00_01_1A_17_44, 1, 1, 0);
    wait_idle(to, df, cyc);
    n = txq.size() - run_base;
    checks++; if (n != 12) begin errors++; $display("FAIL retry_tx_count got=%0d exp=12", n); end
    checks++; if (n == 12 && tx_mism(run_base, 12) != 0) begin errors++; $display("FAIL retry_tx_bytes got=%0d bad exp=0", tx_mism(run_base, 12)); end
    checks++; if (done_cnt - done_base != 1 || error !== 1'b0) begin errors++; $display("FAIL retry_result got=done%0d err%b exp=done1 err0", done_cnt - done_base, error); end
  endtask
  task automatic test_timeout;
    bit to; logic df; int cyc, n;
    launch(40'hA5_5A_3C_C3_7E, 0, 0, 0);
    wait_idle(to, df, cyc);
    n = txq.size() - run_base;
    checks++; if (n != 18) begin errors++; $display("FAIL timeout_tx_count got=%0d exp=18", n); end
    checks++; if (error !== 1'b1 || done_cnt != done_base || df !== 1'b0) begin errors++; $display("FAIL timeout_result got=err%b done%0d exp=err1 done0", error, done_cnt - done_base); end
    checks++; if (cyc < 3 * RT) begin errors++; $display("FAIL timeout_duration got=%0d exp>=%0d", cyc, 3 * RT); end
    checks++; if ({m1, m0} !== 2'b00) begin errors++; $display("FAIL timeout_end_pins got=%b exp=00", {m1, m0}); end
  endtask
  task automatic test_invalid;
    bit to; logic df; int cyc, n;
    launch(40'h12_34_56_78_9A, 1, 0, 1);
    wait_idle(to, df, cyc);
    n = txq.size() - run_base;
    checks++; if (n != 18) begin errors++; $display("FAIL invalid_tx_count got=%0d exp=18", n); end
    checks++; if (error !== 1'b1 || done_cnt != done_base) begin errors++; $display("FAIL invalid_result got=err%b done%0d exp=err1 done0", error, done_cnt - done_base); end
  endtask
  task automatic test_start_ignored;
    bit to; logic df; int cyc, n;
    launch(40'h01_02_03_04_05, 1, 0, 0);
    checks++; if (error !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL restart_clears_error got=err%b busy%b exp=err0 busy1", error, busy); end
    for (int i = 0; i < 2000 && txq.size() < run_base + 6; i++) @(negedge clk);
    checks++; if (txq.size() < run_base + 6) begin errors++; $display("FAIL ignore_reach_recv got=%0d bytes exp=6", txq.size() - run_base); end
    repeat (6) @(negedge clk);
    start = 1; @(negedge clk); start = 0;
    wait_idle(to, df, cyc);
    repeat (MS + 10) @(negedge clk);
    n = txq.size() - run_base;
    checks++; if (done_cnt - done_base != 1 || n != 6 || busy !== 1'b0) begin errors++; $display("FAIL ignore_start got=done%0d tx%0d busy%b exp=done1 tx6 busy0", done_cnt - done_base, n, busy); end
  endtask
  task automatic test_reset_mid_send;
    bit to; logic df; int cyc, n;
    launch(40'hDE_AD_BE_EF_11, 1, 0, 0);
    for (int i = 0; i < 2000 && txq.size() < run_base + 2; i++) @(negedge clk);
    rst = 1;
    @(negedge clk);
    checks++; if (bus.tx_use !== 1'b0 || busy !== 1'b0 || {m1, m0} !== 2'b00) begin errors++; $display("FAIL midreset got=tx%b busy%b pins%b exp=tx0 busy0 pins00", bus.tx_use, busy, {m1, m0}); end
    rst = 0;
    @(negedge clk);
    launch(40'hDE_AD_BE_EF_11, 1, 0, 0);
    wait_idle(to, df, cyc);
    n = txq.size() - run_base;
    checks++; if (n != 6 || done_cnt - done_base != 1 || error !== 1'b0) begin errors++; $display("FAIL after_reset_run got=tx%0d done%0d err%b exp=tx6 done1 err0", n, done_cnt - done_base, error); end
  endtask
  task automatic test_random;
    bit to; logic df; int cyc, n, en, bad, inv, att, ok;
    logic [39:0] p;
    for (int it = 0; it < 5; it++) begin
      p = {8'($urandom), 32'($urandom)};
      en = ($urandom_range(0, 3) != 0) ? 1 : 0;
      bad = $urandom_range(0, 3);
      inv = ($urandom_range(0, 4) == 0) ? 1 : 0;
      model(en, bad, inv, att, ok);
      launch(p, en, bad, inv);
      wait_idle(to, df, cyc);
      n = txq.size() - run_base;
      checks++; if (to) begin errors++; $display("FAIL rand%0d_timeout got=busy exp=idle", it); end
      checks++; if (n != 6 * att) begin errors++; $display("FAIL rand%0d_tx_count got=%0d exp=%0d", it, n, 6 * att); end
      checks++; if (n == 6 * att && tx_mism(run_base, n) != 0) begin errors++; $display("FAIL rand%0d_tx_bytes got=%0d bad exp=0", it, tx_mism(run_base, n)); end
      checks++; if (done_cnt - done_base != ok || error !== 1'(1 - ok)) begin errors++; $display("FAIL rand%0d_result got=done%0d err%b exp=done%0d err%0d", it, done_cnt - done_base, error, ok, 1 - ok); end
    end
  endtask
  initial begin
    test_reset;
    test_basic;
    test_retry_mismatch;
    test_timeout;
    test_invalid;
    test_start_ignored;
    test_reset_mid_send;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
